// File: rtl/vector_operand_fetch_if.sv
// Issue, register-file, writeback and execute bundle for vector_operand_fetch.
// The slave side is the fetch stage; the master side is its environment.
interface vector_operand_fetch_if #(
  parameter int VLEN     = 256,
  parameter int NUM_REGS = 32,
  parameter int OPW      = 8
);
  logic                issue_valid_i;
  logic                issue_ready_o;
  logic [OPW-1:0]      issue_op_i;
  logic [4:0]          issue_vs1_i;
  logic [4:0]          issue_vs2_i;
  logic [4:0]          issue_vd_i;
  logic                issue_wen_i;
  logic [4:0]          rf_raddr1_o;
  logic [4:0]          rf_raddr2_o;
  logic [VLEN-1:0]     rf_rdata1_i;
  logic [VLEN-1:0]     rf_rdata2_i;
  logic                wb_we_i;
  logic [4:0]          wb_waddr_i;
  logic [VLEN-1:0]     wb_wdata_i;
  logic                ex_valid_o;
  logic                ex_ready_i;
  logic [OPW-1:0]      ex_op_o;
  logic [4:0]          ex_vd_o;
  logic                ex_wen_o;
  logic [VLEN-1:0]     ex_opa_o;
  logic [VLEN-1:0]     ex_opb_o;
  logic [NUM_REGS-1:0] sb_pending_o;

  modport slave (
    input  issue_valid_i, issue_op_i, issue_vs1_i, issue_vs2_i,
    input  issue_vd_i, issue_wen_i,
    input  rf_rdata1_i, rf_rdata2_i,
    input  wb_we_i, wb_waddr_i, wb_wdata_i,
    input  ex_ready_i,
    output issue_ready_o, rf_raddr1_o, rf_raddr2_o,
    output ex_valid_o, ex_op_o, ex_vd_o, ex_wen_o,
    output ex_opa_o, ex_opb_o, sb_pending_o
  );

  modport master (
    output issue_valid_i, issue_op_i, issue_vs1_i, issue_vs2_i,
    output issue_vd_i, issue_wen_i,
    output rf_rdata1_i, rf_rdata2_i,
    output wb_we_i, wb_waddr_i, wb_wdata_i,
    output ex_ready_i,
    input  issue_ready_o, rf_raddr1_o, rf_raddr2_o,
    input  ex_valid_o, ex_op_o, ex_vd_o, ex_wen_o,
    input  ex_opa_o, ex_opb_o, sb_pending_o
  );
endinterface

// File: rtl/vector_operand_fetch.sv
// Vector operand fetch: scoreboarded issue, RF read, one-entry output reg.
// Define VOF_BYPASS_EN to forward same-cycle writeback into hazards/operands.
module vector_operand_fetch #(
  parameter int VLEN     = 256,
  parameter int NUM_REGS = 32,
  parameter int OPW      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  vector_operand_fetch_if.slave bus
);

  logic [NUM_REGS-1:0] pend;
  logic [NUM_REGS-1:0] pend_eff;
  logic [NUM_REGS-1:0] clr;
  logic [NUM_REGS-1:0] set;
  logic [VLEN-1:0]     opa_d;
  logic [VLEN-1:0]     opb_d;
  logic                wb_hit;
  logic                hazard;
  logic                slot_free;
  logic                accept;

  logic                ex_valid;
  logic [OPW-1:0]      ex_op;
  logic [4:0]          ex_vd;
  logic                ex_wen;
  logic [VLEN-1:0]     ex_opa;
  logic [VLEN-1:0]     ex_opb;

  assign bus.rf_raddr1_o = bus.issue_vs1_i;
  assign bus.rf_raddr2_o = bus.issue_vs2_i;

  assign wb_hit    = bus.wb_we_i && (bus.wb_waddr_i != 5'd0);
  assign slot_free = !ex_valid || bus.ex_ready_i;

  // Effective pending set and operand selection (forwarding when enabled)
  always_comb begin
    pend_eff = pend;
    opa_d    = bus.rf_rdata1_i;
    opb_d    = bus.rf_rdata2_i;
`ifdef VOF_BYPASS_EN
    if (wb_hit) begin
      pend_eff[bus.wb_waddr_i] = 1'b0;
      if (bus.wb_waddr_i == bus.issue_vs1_i) opa_d = bus.wb_wdata_i;
      if (bus.wb_waddr_i == bus.issue_vs2_i) opb_d = bus.wb_wdata_i;
    end
`endif
  end

  assign hazard = pend_eff[bus.issue_vs1_i]
                | pend_eff[bus.issue_vs2_i]
                | (bus.issue_wen_i & pend_eff[bus.issue_vd_i]);

  assign bus.issue_ready_o = slot_free && !hazard && !rst_i;
  assign accept = bus.issue_valid_i && bus.issue_ready_o;

  // Scoreboard clear/set masks; index 0 never participates
  always_comb begin
    clr = '0;
    set = '0;
    if (wb_hit) clr[bus.wb_waddr_i] = 1'b1;
    if (accept && bus.issue_wen_i && (bus.issue_vd_i != 5'd0))
      set[bus.issue_vd_i] = 1'b1;
  end

  // Scoreboard register; a same-index set overrides the clear
  always_ff @(posedge clk_i) begin
    if (rst_i) pend <= '0;
    else       pend <= (pend & ~clr) | set;
  end

  // Output entry: load on accept, drain on consume, hold otherwise
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid <= 1'b0;
      ex_op    <= '0;
      ex_vd    <= '0;
      ex_wen   <= 1'b0;
      ex_opa   <= '0;
      ex_opb   <= '0;
    end else if (accept) begin
      ex_valid <= 1'b1;
      ex_op    <= bus.issue_op_i;
      ex_vd    <= bus.issue_vd_i;
      ex_wen   <= bus.issue_wen_i;
      ex_opa   <= opa_d;
      ex_opb   <= opb_d;
    end else if (bus.ex_ready_i) begin
      ex_valid <= 1'b0;
    end
  end

  assign bus.ex_valid_o   = ex_valid;
  assign bus.ex_op_o      = ex_op;
  assign bus.ex_vd_o      = ex_vd;
  assign bus.ex_wen_o     = ex_wen;
  assign bus.ex_opa_o     = ex_opa;
  assign bus.ex_opb_o     = ex_opb;
  assign bus.sb_pending_o = pend;

endmodule

// File: tb/tb_vector_operand_fetch.sv
// Directed bench for vector_operand_fetch with a behavioural register file.
// Expectations follow both the bypass and non-bypass builds.
module tb_vector_operand_fetch;

  localparam int VLEN     = 256;
  localparam int NUM_REGS = 32;
  localparam int OPW      = 8;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  int vectors     = 0;
  int miscompares = 0;

  logic [VLEN-1:0] rf [NUM_REGS];

  vector_operand_fetch_if #(.VLEN(VLEN), .NUM_REGS(NUM_REGS), .OPW(OPW)) bus ();

  vector_operand_fetch #(.VLEN(VLEN), .NUM_REGS(NUM_REGS), .OPW(OPW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  // Register file: combinational read of old value, write at clock edge
  always @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NUM_REGS; r++) rf[r] <= '0;
    end else if (bus.wb_we_i && bus.wb_waddr_i != 5'd0) begin
      rf[bus.wb_waddr_i] <= bus.wb_wdata_i;
    end
  end

  assign bus.rf_rdata1_i = (bus.rf_raddr1_o == 5'd0) ? '0 : rf[bus.rf_raddr1_o];
  assign bus.rf_rdata2_i = (bus.rf_raddr2_o == 5'd0) ? '0 : rf[bus.rf_raddr2_o];

  task automatic chk(input string tag, input logic [VLEN-1:0] obs,
                     input logic [VLEN-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [OPW-1:0] op, input logic [4:0] vs1,
                       input logic [4:0] vs2, input logic [4:0] vd,
                       input logic wen);
    bus.issue_valid_i = 1'b1;
    bus.issue_op_i    = op;
    bus.issue_vs1_i   = vs1;
    bus.issue_vs2_i   = vs2;
    bus.issue_vd_i    = vd;
    bus.issue_wen_i   = wen;
  endtask

  task automatic wb(input logic we, input logic [4:0] a,
                    input logic [VLEN-1:0] d);
    bus.wb_we_i    = we;
    bus.wb_waddr_i = a;
    bus.wb_wdata_i = d;
  endtask

  localparam logic [VLEN-1:0] V11 = {32{8'h11}};
  localparam logic [VLEN-1:0] V22 = {32{8'h22}};
  localparam logic [VLEN-1:0] VAB = {32{8'hAB}};
  localparam logic [VLEN-1:0] V55 = {32{8'h55}};
  localparam logic [VLEN-1:0] VFF = {32{8'hFF}};

  initial begin
    bus.issue_valid_i = 1'b0;
    bus.issue_op_i    = '0;
    bus.issue_vs1_i   = '0;
    bus.issue_vs2_i   = '0;
    bus.issue_vd_i    = '0;
    bus.issue_wen_i   = 1'b0;
    bus.ex_ready_i    = 1'b1;
    wb(1'b0, 5'd0, '0);

    tick();
    tick();
    chk("rst_ex_valid", VLEN'(bus.ex_valid_o), '0);
    chk("rst_sb", VLEN'(bus.sb_pending_o), '0);
    chk("rst_ready_low", VLEN'(bus.issue_ready_o), '0);
    chk("rst_opa", bus.ex_opa_o, '0);
    rst_i = 1'b0;

    wb(1'b1, 5'd1, V11);
    tick();
    wb(1'b1, 5'd2, V22);
    tick();
    wb(1'b0, 5'd0, '0);
    chk("preload_sb", VLEN'(bus.sb_pending_o), '0);

    issue(8'h01, 5'd1, 5'd2, 5'd3, 1'b1);
    #1;
    chk("vadd_ready", VLEN'(bus.issue_ready_o), VLEN'(1));
    chk("raddr1", VLEN'(bus.rf_raddr1_o), VLEN'(1));
    tick();
    chk("vadd_valid", VLEN'(bus.ex_valid_o), VLEN'(1));
    chk("vadd_opa", bus.ex_opa_o, V11);
    chk("vadd_opb", bus.ex_opb_o, V22);
    chk("vadd_op", VLEN'(bus.ex_op_o), VLEN'(8'h01));
    chk("vadd_vd", VLEN'(bus.ex_vd_o), VLEN'(3));
    chk("vadd_sb", VLEN'(bus.sb_pending_o), VLEN'(32'h8));

    issue(8'h02, 5'd3, 5'd0, 5'd4, 1'b1);
    #1;
    chk("raw_stall", VLEN'(bus.issue_ready_o), '0);
    tick();
    chk("raw_drain", VLEN'(bus.ex_valid_o), '0);
    wb(1'b1, 5'd3, VAB);
    #1;
`ifdef VOF_BYPASS_EN
    chk("raw_byp_ready", VLEN'(bus.issue_ready_o), VLEN'(1));
    tick();
    wb(1'b0, 5'd0, '0);
`else
    chk("raw_wb_ready", VLEN'(bus.issue_ready_o), '0);
    tick();
    wb(1'b0, 5'd0, '0);
    #1;
    chk("raw_after_ready", VLEN'(bus.issue_ready_o), VLEN'(1));
    tick();
`endif
    chk("raw_valid", VLEN'(bus.ex_valid_o), VLEN'(1));
    chk("raw_opa", bus.ex_opa_o, VAB);
    chk("raw_opb", bus.ex_opb_o, '0);
    chk("raw_sb", VLEN'(bus.sb_pending_o), VLEN'(32'h10));

    issue(8'h03, 5'd1, 5'd2, 5'd5, 1'b1);
    tick();
    chk("waw_first_sb", VLEN'(bus.sb_pending_o), VLEN'(32'h30));
    #1;
    chk("waw_stall", VLEN'(bus.issue_ready_o), '0);
    tick();
    chk("waw_still_stall", VLEN'(bus.issue_ready_o), '0);
    wb(1'b1, 5'd5, V55);
    #1;
`ifdef VOF_BYPASS_EN
    chk("waw_byp_ready", VLEN'(bus.issue_ready_o), VLEN'(1));
    tick();
    wb(1'b0, 5'd0, '0);
`else
    chk("waw_wb_ready", VLEN'(bus.issue_ready_o), '0);
    tick();
    wb(1'b0, 5'd0, '0);
    chk("waw_cleared_sb", VLEN'(bus.sb_pending_o), VLEN'(32'h10));
    #1;
    chk("waw_after_ready", VLEN'(bus.issue_ready_o), VLEN'(1));
    tick();
`endif
    chk("waw_reset_sb", VLEN'(bus.sb_pending_o), VLEN'(32'h30));
    bus.issue_valid_i = 1'b0;
    tick();
    chk("idle_valid", VLEN'(bus.ex_valid_o), '0);

    issue(8'h04, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    issue(8'h05, 5'd2, 5'd1, 5'd0, 1'b0);
    bus.ex_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", VLEN'(bus.issue_ready_o), '0);
      tick();
      chk("bp_valid", VLEN'(bus.ex_valid_o), VLEN'(1));
      chk("bp_op", VLEN'(bus.ex_op_o), VLEN'(8'h04));
      chk("bp_opa", bus.ex_opa_o, V11);
    end
    bus.ex_ready_i = 1'b1;
    #1;
    chk("bp_release_ready", VLEN'(bus.issue_ready_o), VLEN'(1));
    tick();
    chk("bp_repl_valid", VLEN'(bus.ex_valid_o), VLEN'(1));
    chk("bp_repl_op", VLEN'(bus.ex_op_o), VLEN'(8'h05));
    chk("bp_repl_opa", bus.ex_opa_o, V22);

    issue(8'h06, 5'd0, 5'd0, 5'd0, 1'b1);
    wb(1'b1, 5'd0, VFF);
    #1;
    chk("v0_ready", VLEN'(bus.issue_ready_o), VLEN'(1));
    tick();
    chk("v0_sb", VLEN'(bus.sb_pending_o), VLEN'(32'h30));
    chk("v0_again_ready", VLEN'(bus.issue_ready_o), VLEN'(1));
    tick();
    chk("v0_opa", bus.ex_opa_o, '0);
    chk("v0_sb2", VLEN'(bus.sb_pending_o), VLEN'(32'h30));
    wb(1'b0, 5'd0, '0);

    issue(8'h07, 5'd1, 5'd2, 5'd7, 1'b1);
    tick();
    bus.issue_valid_i = 1'b0;
    bus.ex_ready_i    = 1'b0;
    chk("pre_rst_sb", VLEN'(bus.sb_pending_o), VLEN'(32'hB0));
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    bus.ex_ready_i = 1'b1;
    chk("mid_rst_valid", VLEN'(bus.ex_valid_o), '0);
    chk("mid_rst_sb", VLEN'(bus.sb_pending_o), '0);
    chk("mid_rst_op", VLEN'(bus.ex_op_o), '0);
    issue(8'h08, 5'd7, 5'd0, 5'd8, 1'b1);
    #1;
    chk("post_rst_ready", VLEN'(bus.issue_ready_o), VLEN'(1));
    tick();
    chk("post_rst_valid", VLEN'(bus.ex_valid_o), VLEN'(1));
    chk("post_rst_sb", VLEN'(bus.sb_pending_o), VLEN'(32'h100));
    bus.issue_valid_i = 1'b0;
    wb(1'b1, 5'd7, V55);
    tick();
    wb(1'b0, 5'd0, '0);
    chk("stale_wb_sb", VLEN'(bus.sb_pending_o), VLEN'(32'h100));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vector_operand_fetch.md
# vector_operand_fetch

Operand-fetch stage between the vector issue logic and the execution units. Accepts one issued vector instruction per cycle via valid/ready, reads both source operands from `vector_reg_file` through its two read ports, and holds the instruction plus operands in a one-entry output register for the execution stage. A per-register scoreboard tracks outstanding writes. Issue stalls on RAW/WAW hazards until the writeback port (`we_i`/`waddr_i` of `vector_reg_file`) retires the pending write.

## Interface
- `VLEN`, 256, vector register width in bits
- `NUM_REGS`, 32, architectural vector registers; v0 reads as zero and is never pending
- `OPW`, 8, opcode field width

- `clk_i` in 1: single clock, rising edge
- `rst_i` in 1: reset, synchronous, active-high
- `issue_valid_i` in 1: issued instruction valid
- `issue_ready_o` out 1: stage accepts instruction this cycle
- `issue_op_i` in OPW: opcode
- `issue_vs1_i`, `issue_vs2_i` in 5 each: source register indices
- `issue_vd_i` in 5: destination register index
- `issue_wen_i` in 1: instruction writes `vd`
- `rf_raddr1_o`, `rf_raddr2_o` out 5 each: register-file read addresses
- `rf_rdata1_i`, `rf_rdata2_i` in VLEN each: register-file read data, combinational
- `wb_we_i` in 1: writeback strobe, same signal driving the register-file write port
- `wb_waddr_i` in 5: writeback index
- `wb_wdata_i` in VLEN: writeback data
- `ex_valid_o` out 1: output entry valid
- `ex_ready_i` in 1: execution stage consumes the entry
- `ex_op_o` out OPW, `ex_vd_o` out 5, `ex_wen_o` out 1: registered instruction fields
- `ex_opa_o`, `ex_opb_o` out VLEN each: registered operands for vs1 and vs2
- `sb_pending_o` out NUM_REGS: scoreboard bits; bit 0 is constant 0

## Operation
- `rf_raddr1_o = issue_vs1_i` and `rf_raddr2_o = issue_vs2_i` are driven combinationally at all times.
- `slot_free = !ex_valid_o || ex_ready_i`.
- The effective pending set `P` is the scoreboard. With bypass, the bit for `wb_waddr_i` is removed from `P` when `wb_we_i` is high.
- A hazard exists when any of these holds:
  - `P[vs1]`
  - `P[vs2]`
  - `issue_wen_i && P[vd]` (WAW)
- Index 0 never raises a hazard.
- `issue_ready_o = slot_free && !hazard`, combinational, independent of `issue_valid_i`.
- Accept occurs when `issue_valid_i && issue_ready_o`. On accept:
  - Capture op, vd and wen.
  - Capture `rf_rdata1_i` into opa and `rf_rdata2_i` into opb, with bypass substitution applied (see Configuration).
  - Set `ex_valid_o`.
- Without an accept, `ex_ready_i && ex_valid_o` clears `ex_valid_o`. A held entry keeps its fields and operands stable while `!ex_ready_i`.
- Scoreboard updates:
  - `wb_we_i` with a nonzero index clears bit `wb_waddr_i`.
  - An accept with `issue_wen_i` and `vd != 0` sets bit `vd`.
  - If both target the same index in one cycle, the set wins.
  - A clear of a non-pending bit is a no-op.
  - `wb_we_i` to index 0 is ignored.

## Timing
- Latency from accept to `ex_valid_o` is 1 cycle. Throughput is 1 instruction per cycle when `ex_ready_i` is held high and there are no hazards.
- Back-to-back dependent instructions stall until the writeback arrives:
  - With bypass: issue in the same cycle as the writeback.
  - Without bypass: issue the cycle after `wb_we_i`, because register-file read-during-write returns the old value.
- Reset (synchronous, `rst_i` high at a clock edge) clears:
  - `ex_valid_o` to 0.
  - All `ex_*` fields and operands to 0.
  - `sb_pending_o` to 0.
- A held instruction is dropped on reset. `issue_ready_o` is low while `rst_i` is asserted.
- Reset mid-stall discards all pending writes. A writeback arriving after reset is treated as a clear of a non-pending bit.

## Configuration
- `VOF_BYPASS_EN` defined:
  - A same-cycle `wb_we_i` to index r resolves hazards on r.
  - On accept, an operand whose source equals a nonzero `wb_waddr_i` with `wb_we_i` high takes `wb_wdata_i` instead of the register-file data.
  - WAW on r is also resolved in that cycle.
- Undefined: no forwarding mux, and `P` is the raw scoreboard. Stall is one cycle longer per dependency, and operands always come from the register file.

## Test plan
- Reset, then issue `vadd v3<-v1,v2` with v1=0x11..11, v2=0x22..22 and `ex_ready_i`=1: `ex_valid_o` high next cycle, opa=0x11..11, opb=0x22..22, `sb_pending_o[3]`=1.
- With v3 pending, issue `v4<-v3,v0`: `issue_ready_o`=0. Writeback v3=0xAB..AB.
  - Bypass: accepted that cycle, opa=0xAB..AB, opb=0.
  - No bypass: accepted next cycle with the same operands.
- WAW: v5 pending, issue with vd=5: stalled until `wb_we_i`/`wb_waddr_i`=5, then `sb_pending_o[5]` re-set to 1.
- Backpressure: `ex_ready_i`=0 for 3 cycles with the entry held: outputs stable, `issue_ready_o`=0. `ex_ready_i`=1 with a new valid instruction: replacement in the same cycle, no bubble.
- Writes to v0: issue vd=0 with wen=1, and `wb_we_i` to index 0: `sb_pending_o` stays 0 and no stall occurs.
- Assert `rst_i` while an entry is held and v7 is pending: next cycle `ex_valid_o`=0, `sb_pending_o`=0. Issue reading v7 is accepted immediately.
